// File: rtl/write_sram_pkg.sv
// Shared types and defaults for the tile loader (also consumed by read_sram).
// State encodings are fixed 3-bit values so both sides agree on them.
package write_sram_pkg;
  localparam int ADDR_W_DEF     = 16;
  localparam int TILE_WORDS_DEF = 8192;  // 128x128 8-bit pixels, two per word

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOW   = 3'd1,
    S_HIGH  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/write_sram_if.sv
// Pixel stream in, SRAM write port out, plus tile start/done handshake.
interface write_sram_if
  import write_sram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              load_enable;
  logic [7:0]        pixel_in;
  logic              pixel_valid;
  logic              pixel_ready;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_data;
  logic              sram_we_n;
  logic              start_jpeg;
  logic              jpeg_done;
  logic              busy;

  modport slave (
    input  load_enable, pixel_in, pixel_valid, jpeg_done,
    output pixel_ready, sram_addr, sram_data, sram_we_n, start_jpeg, busy
  );

  modport master (
    output load_enable, pixel_in, pixel_valid, jpeg_done,
    input  pixel_ready, sram_addr, sram_data, sram_we_n, start_jpeg, busy
  );
endinterface

// File: rtl/write_sram.sv
// Packs a pixel byte stream into 16-bit little-endian words and writes one tile
// to SRAM, then pulses start_jpeg and waits for jpeg_done. TILE_WORDS <= 2**ADDR_W.
module write_sram
  import write_sram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int TILE_WORDS = TILE_WORDS_DEF
) (
  input  logic         clk,
  input  logic         rst,
  write_sram_if.slave  bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TILE_WORDS - 1);

  state_e            state_q, state_d;
  // The word counter and the word address always move together, so one register serves both.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              we_n_q, we_n_d;
  logic              start_q, start_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      we_n_q  <= 1'b1;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_n_q  <= we_n_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE:
        if (bus.load_enable) begin
          state_d = S_LOW;
          addr_d  = '0;
        end
      S_LOW:
        if (bus.pixel_valid) begin
          data_d[7:0] = bus.pixel_in;
          state_d     = S_HIGH;
        end
      S_HIGH:
        if (bus.pixel_valid) begin
          data_d[15:8] = bus.pixel_in;
          state_d      = S_WRITE;
        end
      S_WRITE:
        if (addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_LOW;
        end
      S_DONE:
        if (bus.jpeg_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Strobe and start are registered off the next state so they align with WRITE / first DONE cycle.
    we_n_d  = (state_d != S_WRITE);
    start_d = (state_q == S_WRITE) && (state_d == S_DONE);
  end

  assign bus.pixel_ready = (state_q == S_LOW) || (state_q == S_HIGH);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.sram_addr   = addr_q;
  assign bus.sram_data   = data_q;
  assign bus.sram_we_n   = we_n_q;
  assign bus.start_jpeg  = start_q;
endmodule

// File: tb/tb_write_sram.sv
// Randomized scoreboard bench: expected SRAM writes are derived from the pixel list
// of each tile; a negedge monitor pops and compares every write and start pulse.
module tb_write_sram;
  localparam int AW   = 4;
  localparam int TW   = 4;
  localparam int NPIX = 2 * TW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  write_sram_if #(.ADDR_W(AW)) bus ();

  write_sram #(.ADDR_W(AW), .TILE_WORDS(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [AW+15:0] exp_q[$];
  int             exp_start_q[$];
  int             starts_seen = 0;
  int             cyc = 0;
  int             last_we_cyc = -10;
  bit             prev_we_low = 1'b0;
  logic [7:0]     px[NPIX];
  int             tile_id = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    cyc++;
    if (bus.sram_we_n === 1'b0) begin
      checks++;
      if (prev_we_low) begin
        failures++;
        $display("FAIL we_pulse_width: strobe low two cycles in a row at cycle %0d", cyc);
      end
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none", bus.sram_addr, bus.sram_data);
      end else begin
        logic [AW+15:0] e;
        e = exp_q.pop_front();
        if ({bus.sram_addr, bus.sram_data} !== e) begin
          failures++;
          $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   bus.sram_addr, bus.sram_data, e[AW+15:16], e[15:0]);
        end
      end
      last_we_cyc = cyc;
    end
    prev_we_low = (bus.sram_we_n === 1'b0);
    if (bus.start_jpeg === 1'b1) begin
      checks++;
      starts_seen++;
      if (exp_start_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_start: start_jpeg at cycle %0d, expected none", cyc);
      end else begin
        void'(exp_start_q.pop_front());
        if (cyc != last_we_cyc + 1 || exp_q.size() != 0) begin
          failures++;
          $display("FAIL start_timing: start at cycle %0d last write %0d pending %0d, expected cycle %0d pending 0",
                   cyc, last_we_cyc, exp_q.size(), last_we_cyc + 1);
        end
      end
    end
  end

  task automatic start_load();
    @(posedge clk); #1 bus.load_enable = 1'b1;
    @(posedge clk); #1 bus.load_enable = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles; returns at posedge+1 of the accepting edge.
  task automatic push_pixel(input logic [7:0] b, input int gap, input bit noise);
    bit ok;
    bus.pixel_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.pixel_in    = b;
    bus.pixel_valid = 1'b1;
    bus.load_enable = noise;
    bus.jpeg_done   = noise;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.pixel_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      failures++;
      $display("FAIL pixel_timeout: pixel_ready never rose, expected handshake");
    end
    @(posedge clk); #1;
    bus.pixel_valid = 1'b0;
    bus.load_enable = 1'b0;
    bus.jpeg_done   = 1'b0;
  endtask

  task automatic wait_start(input int target);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (starts_seen >= target) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      failures++;
      $display("FAIL start_timeout: starts %0d expected %0d", starts_seen, target);
    end
  endtask

  task automatic run_tile(input bit rand_data, input int gap_max, input int noise_at, input bit done_le);
    int target;
    for (int i = 0; i < NPIX; i++) px[i] = rand_data ? 8'($urandom) : 8'(i + 1);
    for (int w = 0; w < TW; w++) exp_q.push_back({AW'(w), px[2*w+1], px[2*w]});
    exp_start_q.push_back(tile_id++);
    target = starts_seen + 1;
    start_load();
    for (int i = 0; i < NPIX; i++)
      push_pixel(px[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0, i == noise_at);
    wait_start(target);
    @(posedge clk); #1;
    chk("busy_in_done", 32'(bus.busy), 32'd1);
    // load_enable alone in DONE must be ignored
    bus.load_enable = 1'b1;
    @(posedge clk); #1 bus.load_enable = 1'b0;
    chk("busy_after_le_in_done", 32'(bus.busy), 32'd1);
    bus.jpeg_done   = 1'b1;
    bus.load_enable = done_le;
    @(posedge clk); #1;
    bus.jpeg_done   = 1'b0;
    bus.load_enable = 1'b0;
    chk("busy_after_done", 32'(bus.busy), 32'd0);
    chk("ready_after_done", 32'(bus.pixel_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("idle_after_done", 32'(bus.busy), 32'd0);
    chk("start_count", 32'(starts_seen), 32'(target));
  endtask

  task automatic abort_tile();
    int s0;
    s0 = starts_seen;
    for (int i = 0; i < NPIX; i++) px[i] = 8'($urandom);
    for (int w = 0; w < 2; w++) exp_q.push_back({AW'(w), px[2*w+1], px[2*w]});
    start_load();
    for (int i = 0; i < 6; i++) push_pixel(px[i], int'($urandom_range(0, 1)), 1'b0);
    chk("abort_in_write_we", 32'(bus.sram_we_n), 32'd0);
    chk("abort_in_write_addr", 32'(bus.sram_addr), 32'd2);
    rst = 1'b0;
    #1;
    chk("abort_we_n", 32'(bus.sram_we_n), 32'd1);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_addr", 32'(bus.sram_addr), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("abort_stays_idle", 32'(bus.busy), 32'd0);
    chk("abort_no_start", 32'(starts_seen), 32'(s0));
    chk("abort_pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.load_enable = 1'b0;
    bus.pixel_in    = '0;
    bus.pixel_valid = 1'b0;
    bus.jpeg_done   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", 32'(bus.sram_addr), 32'd0);
    chk("rst_data", 32'(bus.sram_data), 32'd0);
    chk("rst_we_n", 32'(bus.sram_we_n), 32'd1);
    chk("rst_ready", 32'(bus.pixel_ready), 32'd0);
    chk("rst_start", 32'(bus.start_jpeg), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk) rst = 1'b1;

    // valid pixels offered in IDLE without a load request
    @(posedge clk); #1 bus.pixel_valid = 1'b1;
    bus.pixel_in = 8'hAA;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_ready", 32'(bus.pixel_ready), 32'd0);
      chk("idle_we_n", 32'(bus.sram_we_n), 32'd1);
    end
    @(posedge clk); #1 bus.pixel_valid = 1'b0;

    run_tile(1'b0, 0, -1, 1'b1);   // 0x01..0x08 back-to-back, load with jpeg_done
    run_tile(1'b0, 2, -1, 1'b0);   // same bytes, valid toggling
    run_tile(1'b1, 1, 3, 1'b1);    // load_enable/jpeg_done noise mid-tile
    abort_tile();
    run_tile(1'b0, 0, -1, 1'b0);   // fresh load after abort restarts at 0
    for (int t = 0; t < 5; t++) run_tile(1'b1, 2, int'($urandom_range(0, NPIX - 1)), 1'($urandom));

    repeat (4) @(posedge clk);
    chk("final_pending_writes", 32'(exp_q.size()), 32'd0);
    chk("final_pending_starts", 32'(exp_start_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/write_sram.md
WRITE_SRAM -- requirements
Module: write_sram

Interface
REQ-001 Parameter ADDR_W, default 16: SRAM word-address width.
REQ-002 Parameter TILE_WORDS, default 8192: 16-bit words per tile (128x128 8-bit pixels).
REQ-003 clk  input  1: single clock; all logic rising-edge.
REQ-004 rst  input  1: reset, asynchronous, active-low.
REQ-005 load_enable  input  1: one-cycle request to start loading a tile.
REQ-006 pixel_in  input  8: incoming pixel byte.
REQ-007 pixel_valid  input  1: pixel_in valid this cycle.
REQ-008 pixel_ready  output  1: block accepts pixel_in this cycle.
REQ-009 sram_addr  output  ADDR_W: SRAM word address.
REQ-010 sram_data  output  16: SRAM write data.
REQ-011 sram_we_n  output  1: SRAM write strobe, active-low.
REQ-012 start_jpeg  output  1: one-cycle pulse, tile fully in SRAM; drives read_sram start_jpeg.
REQ-013 jpeg_done  input  1: one-cycle pulse, downstream finished with tile.
REQ-014 busy  output  1: high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, LOW_BYTE, HIGH_BYTE, WRITE, DONE; registered state, combinational next-state.
REQ-016 IDLE: pixel_ready=0; load_enable=1 -> LOW_BYTE, word counter and sram_addr cleared to 0.
REQ-017 LOW_BYTE: pixel_ready=1; on pixel_valid&pixel_ready, pixel_in latched into sram_data[7:0] -> HIGH_BYTE.
REQ-018 HIGH_BYTE: pixel_ready=1; on handshake, pixel_in latched into sram_data[15:8] -> WRITE.
REQ-019 Without pixel_valid, LOW_BYTE/HIGH_BYTE hold; no timeout.
REQ-020 WRITE: exactly one cycle; pixel_ready=0, sram_we_n=0; sram_addr and sram_data stable through the whole cycle.
REQ-021 WRITE exit: if word counter = TILE_WORDS-1 -> DONE, else counter+1, sram_addr+1 -> LOW_BYTE; both updates on the same edge.
REQ-022 Throughput: 2 pixels per 3 cycles at best; pixel order little-endian within each word.
REQ-023 start_jpeg = 1 for exactly the first cycle in DONE (registered, one cycle after the last WRITE cycle).
REQ-024 DONE: pixel_ready=0, sram_we_n=1; jpeg_done=1 -> IDLE.
REQ-025 load_enable outside IDLE ignored, including the cycle it coincides with jpeg_done in DONE.
REQ-026 jpeg_done outside DONE ignored.
REQ-027 sram_addr never wraps within a tile; TILE_WORDS <= 2**ADDR_W required.
REQ-028 sram_data holds its last value outside WRITE; meaningful only while sram_we_n=0.

Reset
REQ-029 rst=0 immediately forces: state IDLE, sram_addr 0, sram_data 0, counter 0, sram_we_n 1, pixel_ready 0, start_jpeg 0, busy 0.
REQ-030 Reset mid-tile, including during WRITE, aborts the tile; no partial start_jpeg; a new load_enable is needed after release.

Structure
REQ-031 State encodings (3-bit), ADDR_W and TILE_WORDS defaults live in the shared JPEG2000 defines include, also used by read_sram.
REQ-032 Single module; no sub-module is natural at this size.
REQ-033 All outputs registered except pixel_ready and busy, which decode state.

Verification (TILE_WORDS=4, ADDR_W=4)
REQ-034 Reset then load_enable, 8 back-to-back pixels 0x01..0x08 -> writes 0x0201@0, 0x0403@1, 0x0605@2, 0x0807@3; each sram_we_n low for 1 cycle; start_jpeg one pulse one cycle after the last write.
REQ-035 pixel_valid toggled 1-0-1 during the tile -> identical SRAM contents to REQ-034; no write while waiting on the high byte.
REQ-036 load_enable pulsed in LOW_BYTE and in DONE -> no counter or address reset, no second start_jpeg.
REQ-037 rst asserted during the WRITE cycle of word 2 -> sram_we_n=1 the same instant; no start_jpeg; a fresh load restarts at address 0.
REQ-038 jpeg_done with load_enable in DONE -> IDLE next cycle, busy=0; a following load_enable starts a new tile at address 0.
REQ-039 pixel_valid=1 in IDLE without load_enable for 10 cycles -> pixel_ready=0, no SRAM write.
